sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DSIZE, default 8, data width in bits.
REQ-002 Parameter ASIZE, default 3, address width; DEPTH = 2**ASIZE entries.
REQ-003 Parameter AF_THRESH, default DEPTH-2, level at or above which walmost_full asserts.
REQ-004 Parameter AE_THRESH, default 2, level at or below which ralmost_empty asserts.
REQ-005 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wdata  input  DSIZE  write data.
REQ-009 winc  input  1  write request.
REQ-010 rinc  input  1  read/pop request.
REQ-011 flag_clr  input  1  synchronous clear of the sticky error flags.
REQ-012 rdata  output  DSIZE  read data.
REQ-013 wfull  output  1  FIFO holds DEPTH entries.
REQ-014 rempty  output  1  FIFO holds 0 entries.
REQ-015 walmost_full  output  1  level >= AF_THRESH.
REQ-016 ralmost_empty  output  1  level <= AE_THRESH.
REQ-017 level  output  ASIZE+1  current occupancy, 0..DEPTH.
REQ-018 overflow  output  1  sticky: write attempted while full.
REQ-019 underflow  output  1  sticky: read attempted while empty.

Function
REQ-020 Write accepted iff winc && !wfull; wdata stored at write pointer, pointer increments modulo DEPTH.
REQ-021 Read accepted iff rinc && !rempty; read pointer increments modulo DEPTH.
REQ-022 Full/empty gating uses pre-edge flags: write while full is rejected even with a simultaneous accepted read; read while empty is rejected even with a simultaneous write (no bypass).
REQ-023 level updates on the same edge: +1 write only, -1 read only, unchanged when both or neither accepted.
REQ-024 wfull, rempty, walmost_full, ralmost_empty are registered and consistent with level in the same cycle.
REQ-025 Pointers carry an extra wrap bit (ASIZE+1 bits); full = addresses equal and wrap bits differ; empty = pointers equal.
REQ-026 FWFT=0: rdata loads the head entry on the edge accepting the read (1-cycle latency); rdata holds its value otherwise.
REQ-027 FWFT=1: rdata presents the head entry whenever rempty=0, valid in the cycle after the write edge that made the FIFO non-empty; rinc pops it; rdata undefined-but-stable when rempty=1.
REQ-028 overflow sets on any edge with winc && wfull; underflow sets on any edge with rinc && rempty; both hold until flag_clr or rst.
REQ-029 flag_clr coincident with a new error event: set wins.
REQ-030 Rejected operations do not change memory, pointers, level or rdata.

Reset
REQ-031 rst high on an edge: pointers 0, level 0, rempty 1, wfull 0, ralmost_empty 1, walmost_full 0, overflow 0, underflow 0, rdata 0.
REQ-032 rst overrides all concurrent winc/rinc/flag_clr; memory contents are not reset.
REQ-033 rst asserted mid-operation discards all stored entries; first post-reset write behaves as into an empty FIFO.

Structure
REQ-034 Package sync_fifo_pkg holds default DSIZE, ASIZE, threshold constants and the FWFT mode encodings.
REQ-035 Storage is a sub-module fifo_mem: DEPTH x DSIZE, synchronous write, asynchronous read, no reset.
REQ-036 Pointer, level, flag and sticky-error logic reside in sync_fifo.

Verification (DSIZE=8, ASIZE=3, AF_THRESH=6, AE_THRESH=2)
REQ-037 Reset, write 0x11..0x18 -> level 1..8, walmost_full from 6th write, wfull after 8th, rempty 0 after 1st.
REQ-038 9th write 0xAA while full -> rejected, overflow=1, level 8; then 8 reads return 0x11..0x18 in order, rempty=1 after 8th.
REQ-039 rinc on empty FIFO -> underflow=1, level 0, rdata unchanged; flag_clr -> underflow=0 next cycle.
REQ-040 Simultaneous winc/rinc at level 4 -> level stays 4, order preserved; at level 0 -> only write accepted, level 1; at level 8 -> only read accepted, level 7.
REQ-041 FWFT=1: write 0x5A into empty FIFO -> cycle after write edge rempty=0, rdata=0x5A without rinc; rinc -> rempty=1.
REQ-042 rst pulse at level 5 with overflow=1 -> next cycle level 0, rempty 1, overflow 0, rdata 0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry, thresholds and read-mode encodings.
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_DSIZE     = 8;
  localparam int unsigned DEFAULT_ASIZE     = 3;
  localparam int unsigned DEFAULT_AF_MARGIN = 2;
  localparam int unsigned DEFAULT_AE_THRESH = 2;

  // Read-mode encodings for the FWFT parameter
  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DEFAULT_DSIZE,
  parameter int unsigned ASIZE = DEFAULT_ASIZE
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, occupancy level, sticky error
// flags and a selectable registered-read or first-word-fall-through read port.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = DEFAULT_DSIZE,
  parameter int unsigned ASIZE     = DEFAULT_ASIZE,
  parameter int unsigned AF_THRESH = (1 << ASIZE) - DEFAULT_AF_MARGIN,
  parameter int unsigned AE_THRESH = DEFAULT_AE_THRESH,
  parameter int unsigned FWFT      = FWFT_OFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             flag_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = ASIZE + 1;

  logic [PW-1:0]    wptr, rptr;
  logic [PW-1:0]    wptr_n, rptr_n, level_n;
  logic             wr_ok_c, rd_ok_c;
  logic [ASIZE-1:0] raddr_c;
  logic [DSIZE-1:0] mem_rdata_c;
  logic [DSIZE-1:0] rdata_n;

  // Gating uses the pre-edge flags only, so there is no full/empty bypass
  assign wr_ok_c = winc && !wfull;
  assign rd_ok_c = rinc && !rempty;

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .we      (wr_ok_c && !rst),
    .waddr   (wptr[ASIZE-1:0]),
    .wdata   (wdata),
    .raddr   (raddr_c),
    .rdata_c (mem_rdata_c)
  );

  // FWFT pre-fetches the entry that will be head after this edge
  assign raddr_c = (FWFT == FWFT_ON) ? rptr_n[ASIZE-1:0] : rptr[ASIZE-1:0];

  // Next pointers and occupancy
  always_comb begin
    wptr_n  = wptr + PW'(wr_ok_c);
    rptr_n  = rptr + PW'(rd_ok_c);
    level_n = level;
    if (wr_ok_c && !rd_ok_c)      level_n = level + PW'(1);
    else if (rd_ok_c && !wr_ok_c) level_n = level - PW'(1);
  end

  // Next read data; in FWFT a write into an otherwise-empty FIFO becomes head directly
  always_comb begin
    rdata_n = rdata;
    if (FWFT == FWFT_ON) begin
      if (level_n != '0) begin
        if (wr_ok_c && (rptr_n[ASIZE-1:0] == wptr[ASIZE-1:0])) rdata_n = wdata;
        else                                                   rdata_n = mem_rdata_c;
      end
    end else if (rd_ok_c) begin
      rdata_n = mem_rdata_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      level         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      rdata         <= '0;
    end else begin
      wptr          <= wptr_n;
      rptr          <= rptr_n;
      level         <= level_n;
      wfull         <= (wptr_n[ASIZE-1:0] == rptr_n[ASIZE-1:0]) && (wptr_n[ASIZE] != rptr_n[ASIZE]);
      rempty        <= (wptr_n == rptr_n);
      walmost_full  <= (level_n >= PW'(AF_THRESH));
      ralmost_empty <= (level_n <= PW'(AE_THRESH));
      // A new error event wins over a coincident clear
      overflow      <= (winc && wfull) || (overflow && !flag_clr);
      underflow     <= (rinc && rempty) || (underflow && !flag_clr);
      rdata         <= rdata_n;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one registered-read and one FWFT instance share stimulus and
// are compared every cycle against a queue-based model, plus directed literal checks.
module tb_sync_fifo;

  localparam int unsigned DEPTH = 8;

  logic       clk;
  logic       rst;
  logic [7:0] wdata;
  logic       winc, rinc, flag_clr;

  logic [7:0] rdata0, rdata1;
  logic       wfull0, rempty0, waf0, rae0, ovf0, unf0;
  logic       wfull1, rempty1, waf1, rae1, ovf1, unf1;
  logic [3:0] level0, level1;

  int tests  = 0;
  int errors = 0;

  sync_fifo #(.DSIZE(8), .ASIZE(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .flag_clr(flag_clr),
    .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .walmost_full(waf0),
    .ralmost_empty(rae0), .level(level0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo #(.DSIZE(8), .ASIZE(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .flag_clr(flag_clr),
    .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .walmost_full(waf1),
    .ralmost_empty(rae1), .level(level1), .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, sticky bits, last registered-read value
  logic [7:0] q[$];
  logic       m_ovf, m_unf;
  logic [7:0] m_r0;
  bit         mvalid = 0;
  bit         after_rst;

  initial begin
    forever begin
      @(posedge clk);
      after_rst = 0;
      if (rst) begin
        q.delete();
        m_ovf = 0; m_unf = 0; m_r0 = 8'h00;
        mvalid = 1; after_rst = 1;
      end else if (mvalid) begin
        bit full, empty;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        m_ovf = (winc && full)  || (m_ovf && !flag_clr);
        m_unf = (rinc && empty) || (m_unf && !flag_clr);
        if (rinc && !empty) m_r0 = q.pop_front();
        if (winc && !full)  q.push_back(wdata);
      end
      #1;
      if (mvalid) begin
        int n;
        n = q.size();
        check("f0_level", level0, n);          check("f1_level", level1, n);
        check("f0_wfull", wfull0, n == DEPTH); check("f1_wfull", wfull1, n == DEPTH);
        check("f0_rempty", rempty0, n == 0);   check("f1_rempty", rempty1, n == 0);
        check("f0_waf", waf0, n >= 6);         check("f1_waf", waf1, n >= 6);
        check("f0_rae", rae0, n <= 2);         check("f1_rae", rae1, n <= 2);
        check("f0_ovf", ovf0, m_ovf);          check("f1_ovf", ovf1, m_ovf);
        check("f0_unf", unf0, m_unf);          check("f1_unf", unf1, m_unf);
        check("f0_rdata", rdata0, m_r0);
        if (n > 0)          check("f1_head", rdata1, q[0]);
        else if (after_rst) check("f1_rst_rdata", rdata1, 0);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge; returns after the next falling edge
  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic c, input logic rs);
    winc = w; rinc = r; wdata = d; flag_clr = c; rst = rs;
    @(negedge clk);
  endtask

  initial begin
    winc = 0; rinc = 0; wdata = 0; flag_clr = 0; rst = 1;
    @(negedge clk);
    step(0, 0, 8'h00, 0, 1);
    check("lit_rst_level", level0, 0);
    check("lit_rst_rempty", rempty0, 1);
    check("lit_rst_rae", rae0, 1);
    check("lit_rst_rdata0", rdata0, 0);
    check("lit_rst_rdata1", rdata1, 0);

    // Fill 0x11..0x18
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 8'(8'h10 + i), 0, 0);
      check("lit_fill_level", level0, i);
      check("lit_fill_waf", waf0, i >= 6);
      check("lit_fill_wfull", wfull0, i == 8);
      check("lit_fill_rempty", rempty0, 0);
      check("lit_fill_head1", rdata1, 8'h11);
    end
    step(1, 0, 8'hAA, 0, 0);
    check("lit_ovf", ovf0, 1);
    check("lit_ovf_level", level0, 8);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 8'h00, 0, 0);
      check("lit_drain_rdata", rdata0, 8'(8'h10 + i));
      check("lit_drain_rempty", rempty0, i == 8);
    end

    // Underflow and clear
    step(0, 1, 8'h00, 0, 0);
    check("lit_unf", unf0, 1);
    check("lit_unf_level", level0, 0);
    check("lit_unf_rdata", rdata0, 8'h18);
    step(0, 0, 8'h00, 1, 0);
    check("lit_clr_unf", unf0, 0);
    check("lit_clr_ovf", ovf0, 0);

    // Simultaneous read/write at empty, mid and full
    step(1, 1, 8'h30, 0, 0);
    check("lit_sim0_level", level0, 1);
    check("lit_sim0_unf", unf0, 1);
    check("lit_fwft_head", rdata1, 8'h30);
    for (int i = 1; i <= 3; i++) step(1, 0, 8'(8'h30 + i), 0, 0);
    step(1, 1, 8'h34, 0, 0);
    check("lit_sim4_level", level0, 4);
    check("lit_sim4_rdata", rdata0, 8'h30);
    for (int i = 5; i <= 8; i++) step(1, 0, 8'(8'h30 + i), 0, 0);
    check("lit_refill_level", level0, 8);
    step(1, 1, 8'h99, 0, 0);
    check("lit_sim8_level", level0, 7);
    check("lit_sim8_rdata", rdata0, 8'h31);
    check("lit_sim8_ovf", ovf0, 1);
    for (int i = 2; i <= 8; i++) begin
      step(0, 1, 8'h00, 0, 0);
      check("lit_order_rdata", rdata0, 8'(8'h30 + i));
    end
    check("lit_order_empty", rempty0, 1);

    // Reset at level 5 with overflow set, with concurrent requests
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i), 0, 0);
    check("lit_pre_rst_level", level0, 5);
    check("lit_pre_rst_ovf", ovf0, 1);
    step(1, 1, 8'hEE, 1, 1);
    check("lit_rst5_level", level0, 0);
    check("lit_rst5_rempty", rempty0, 1);
    check("lit_rst5_ovf", ovf0, 0);
    check("lit_rst5_rdata0", rdata0, 0);
    check("lit_rst5_rdata1", rdata1, 0);
    step(1, 0, 8'h5A, 0, 0);
    check("lit_post_rst_level", level1, 1);
    check("lit_post_rst_head", rdata1, 8'h5A);
    step(0, 1, 8'h00, 0, 0);
    check("lit_post_rst_rdata0", rdata0, 8'h5A);
    check("lit_fwft_pop_empty", rempty1, 1);

    // Randomised traffic with per-block bias so full and empty are both visited
    for (int blk = 0; blk < 30; blk++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
             8'($urandom_range(0, 255)), $urandom_range(0, 99) < 3,
             $urandom_range(0, 999) < 5);
      end
    end

    step(0, 0, 8'h00, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
